// File: rtl/lib_voq_rr_scheduler.sv
`default_nettype none
// ============================================================================
// lib_voq_rr_scheduler
//   Round-robin pop scheduler over M VOQ channels feeding a 2-entry output FIFO.
//   Revision: 1.0
// ============================================================================
module lib_voq_rr_scheduler #(
  parameter int M      = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic [0:M-1]      i_data_val,
  output logic [0:M-1]      o_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_val,
  input  logic              i_en
);

  localparam int RR_W = $clog2(M);

  logic [DATA_W-1:0] r_mem [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [RR_W-1:0]   r_rr;

  logic              w_can_grant;
  logic              w_found;
  logic [RR_W-1:0]   w_gidx;
  logic              w_pop;

  function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= M) s = s - M;
    return RR_W'(s);
  endfunction

  // Reset gates the grant so o_en drops the moment reset asserts.
  assign w_can_grant = (r_count != 2'd2) && !reset;
  assign w_pop       = (r_count != 2'd0) && i_en;
  assign o_data_val  = (r_count != 2'd0);
  assign o_data      = r_mem[r_rd_ptr];

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    if (w_can_grant) begin
      for (int k = 0; k < M; k++) begin
        if (!w_found && i_data_val[wrap_idx(r_rr, k)]) begin
          w_found = 1'b1;
          w_gidx  = wrap_idx(r_rr, k);
        end
      end
    end
  end

  always_comb begin
    o_en = '0;
    if (w_found) o_en[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_rr     <= '0;
    end else begin
      if (w_found) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
        r_rr            <= (w_gidx == RR_W'(M - 1)) ? '0 : w_gidx + 1'b1;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_found, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lib_voq_rr_scheduler.md
Name: lib_voq_rr_scheduler

Overview:
Output scheduler that sits directly downstream of a virtual output queue (VOQ) input buffer.
- Arbitrates round-robin among the M per-output-channel valid lines from the VOQ.
- Returns a onehot enable to the VOQ to pop exactly one channel per cycle.
- Captures the popped packet into a 2-entry output buffer that drives the switch/downstream port under a valid/enable handshake.
- The buffer decouples the grant from downstream backpressure, so o_en never depends combinationally on i_en.

Parameters:
M, 5, number of virtual channels (VOQ outputs) arbitrated; M >= 2.

Ports:
clk  input  1  clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
i_data  input  packet_t  packet from VOQ, selected by the VOQ according to o_en, valid in the same cycle as o_en.
i_data_val  input  [0:M-1]  per-channel non-empty flags from VOQ; index 0 is leftmost (MSB).
o_en  output  [0:M-1]  onehot grant/pop to VOQ; all-zero when no grant; index 0 is leftmost.
o_data  output  packet_t  head entry of output buffer.
o_data_val  output  1  head entry valid.
i_en  input  1  downstream accepts o_data this cycle when o_data_val=1.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - o_en=0, o_data_val=0, o_data=0.
  - Buffer count=0, read/write pointers=0, round-robin pointer rr=0.
  - Contents are discarded mid-operation; the first grant after reset considers channel 0 first.
- Output buffer:
  - 2-entry FIFO; count in {0,1,2}.
  - o_data_val = (count != 0); o_data = entry at read pointer (registered, no combinational path from i_data).
- Grant eligibility: can_grant = (count < 2). This depends only on registered state.
- Arbitration (combinational from i_data_val, rr, can_grant):
  - If can_grant and i_data_val != 0, select the first set index searching rr, rr+1, ..., M-1, 0, ..., rr-1.
  - o_en is that index onehot.
  - Otherwise o_en = 0.
  - o_en is never multi-hot; bench asserts $onehot0(o_en) every cycle.
- Capture: in any cycle with o_en != 0, i_data is written at the write pointer at the clock edge.
- Pointer update: rr <= (g+1) mod M on a grant of index g; rr holds when there is no grant.
- Drain: when o_data_val and i_en, the head is popped at the clock edge.
- Count update per cycle:
  - +1 on grant only.
  - -1 on pop only.
  - Unchanged on simultaneous grant and pop (valid at count 1; at count 2 no grant occurs).
- Pointer wrap: read/write pointers wrap 1 -> 0.
- i_en while o_data_val=0 is ignored.
- Latency: grant in cycle N -> packet on o_data with o_data_val=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 packet/cycle sustained with i_en held high.
- Full (count=2): o_en=0 regardless of requests; o_data is held stable until accepted.
- Empty (count=0): o_data_val=0; o_data value is don't-care but must not be X after reset.
- A requester that drops i_data_val before being granted is simply skipped; no state is retained per channel.

Test Plan:
- Reset, then i_data_val=5'b00100, i_en=1, i_data increments per grant -> o_en=5'b00100 every cycle from cycle 0; o_data_val=1 from cycle 1; o_data sequence matches i_data one cycle later; no gaps.
- All channels requesting (5'b11111), i_en=1 -> grant order 0,1,2,3,4,0,1 (o_en 10000, 01000, 00100, 00010, 00001, 10000, ...); output packets in the same order.
- i_en=0, all requesting -> exactly two grants (channels 0,1), then o_en=0; o_data holds packet from ch0. Raise i_en -> ch0 then ch1 delivered, new grants resume at ch2, one per cycle.
- rr=2 after granting ch1, then requests 5'b01010 -> grant ch3 first, then ch1 (wrap), then ch3.
- Count=1 with simultaneous pop and grant -> count stays 1, o_data updates to the new packet next cycle, o_data_val stays 1.
- Assert reset asynchronously (mid-cycle) with count=2 and requests pending -> o_data_val and o_en drop to 0 immediately without waiting for clk. After release with requests 5'b00011 -> first grant is ch3 (index 3, o_en=5'b00010), since rr restarts at 0 and index 3 is the first set index from 0.
